cube_pixel_serializer: RTL and testbench

- Parametrised successor to the cube raster shifter. Pure RTL, with no datapath primitive.
- Accepts whole pixels (COLORS x COLOR_BITS per channel) for CHANNELS parallel LED strings over a valid/ready handshake.
- Applies a per-frame brightness right-shift, then serialises each pixel MSB- or LSB-first as one-wire pulse-width-coded bits (T0H/T1H high time within TBIT cycles).
- Ends a frame with a low latch period. Sits between the raster frame fetcher and the cube's string driver pins.

---
 rtl/cube_raster_pkg.sv | 31 +++
 rtl/cube_bit_encoder.sv | 47 ++++
 rtl/cube_pixel_serializer.sv | 136 +++++++++++++
 tb/tb_cube_pixel_serializer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_raster_pkg.sv
// rtl/cube_raster_pkg.sv - shared FSM type, width helpers and brightness scaling
package cube_raster_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_e;

  localparam int MAX_PB = 256;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pixel_bits(input int colors, input int color_bits);
    return colors * color_bits;
  endfunction

  function automatic logic [MAX_PB-1:0] scale_pixel(input logic [MAX_PB-1:0] data,
                                                    input int dim, input int colors,
                                                    input int color_bits);
    logic [MAX_PB-1:0] res;
    res = '0;
    for (int f = 0; f < colors; f++)
      for (int b = 0; b < color_bits; b++)
        if (b + dim < color_bits) res[f*color_bits + b] = data[f*color_bits + b + dim];
    return res;
  endfunction

endpackage

// File: rtl/cube_bit_encoder.sv
// rtl/cube_bit_encoder.sv - bit-phase counter and per-channel pulse-width encoder
module cube_bit_encoder import cube_raster_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int TBIT     = 10,
  parameter int T0H      = 3,
  parameter int T1H      = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_i,
  input  logic [CHANNELS-1:0] bits_i,
  output logic                phase_last_o,
  output logic [CHANNELS-1:0] sout_o
);

  localparam int PW = clog2(TBIT);
  localparam logic [PW-1:0] PH_LAST = PW'(TBIT - 1);
  localparam logic [PW-1:0] HI0     = PW'(T0H);
  localparam logic [PW-1:0] HI1     = PW'(T1H);

  logic [PW-1:0]       phase_q, phase_d;
  logic [CHANNELS-1:0] sout_q, sout_d;

  assign phase_last_o = run_i && (phase_q == PH_LAST);
  assign sout_o       = sout_q;

  // Phase rests at zero outside SHIFT so each pixel starts on a clean bit boundary.
  always_comb begin
    phase_d = '0;
    if (run_i && !phase_last_o) phase_d = phase_q + 1'b1;
    sout_d = '0;
    if (run_i)
      for (int c = 0; c < CHANNELS; c++)
        sout_d[c] = (phase_q < (bits_i[c] ? HI1 : HI0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      sout_q  <= '0;
    end else begin
      phase_q <= phase_d;
      sout_q  <= sout_d;
    end
  end

endmodule

// File: rtl/cube_pixel_serializer.sv
// rtl/cube_pixel_serializer.sv - pixel buffer, dimming and frame FSM for one-wire LED strings
module cube_pixel_serializer import cube_raster_pkg::*; #(
  parameter int CHANNELS     = 4,
  parameter int COLORS       = 3,
  parameter int COLOR_BITS   = 8,
  parameter int TBIT         = 10,
  parameter int T0H          = 3,
  parameter int T1H          = 7,
  parameter int LATCH_CYCLES = 500,
  parameter int MSB_FIRST    = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [CHANNELS*COLORS*COLOR_BITS-1:0] pix_data,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic                                  frame_end,
  input  logic [clog2(COLOR_BITS)-1:0]          dim,
  output logic [CHANNELS-1:0]                   sout,
  output logic                                  busy,
  output logic                                  underrun
);

  localparam int PB = pixel_bits(COLORS, COLOR_BITS);
  localparam int DW = clog2(COLOR_BITS);
  localparam int BW = clog2(PB);
  localparam int LW = clog2(LATCH_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(PB - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  state_e                 state_q;
  logic [CHANNELS*PB-1:0] hold_q, shreg_q, scaled, shifted;
  logic                   hold_v_q, frame_pend_q, underrun_q;
  logic [DW-1:0]          dim_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [LW-1:0]          latch_cnt_q;
  logic [CHANNELS-1:0]    cur_bit;
  logic                   phase_last, take;

  assign take      = pix_valid && !hold_v_q;
  assign pix_ready = !hold_v_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign scaled[c*PB +: PB] =
      PB'(scale_pixel(MAX_PB'(hold_q[c*PB +: PB]), int'(dim_q), COLORS, COLOR_BITS));
    if (MSB_FIRST != 0) begin : g_msb
      assign cur_bit[c]          = shreg_q[c*PB + PB - 1];
      assign shifted[c*PB +: PB] = {shreg_q[c*PB +: PB-1], 1'b0};
    end else begin : g_lsb
      assign cur_bit[c]          = shreg_q[c*PB];
      assign shifted[c*PB +: PB] = {1'b0, shreg_q[c*PB + 1 +: PB-1]};
    end
  end

  cube_bit_encoder #(
    .CHANNELS (CHANNELS),
    .TBIT     (TBIT),
    .T0H      (T0H),
    .T1H      (T1H)
  ) u_enc (
    .clk          (clk),
    .reset        (reset),
    .run_i        (state_q == SHIFT),
    .bits_i       (cur_bit),
    .phase_last_o (phase_last),
    .sout_o       (sout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      frame_pend_q <= 1'b0;
      underrun_q   <= 1'b0;
      dim_q        <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      latch_cnt_q  <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (frame_end && (state_q != IDLE || hold_v_q)) frame_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (hold_v_q) begin
            state_q <= LOAD;
            dim_q   <= dim;
          end else if (frame_end) begin
            state_q     <= LATCH;
            latch_cnt_q <= '0;
          end
        end
        LOAD: begin
          shreg_q   <= scaled;
          hold_v_q  <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (phase_last) begin
            if (bit_cnt_q == BIT_LAST) begin
              // A waiting pixel reloads here directly so the strings see no gap.
              if (hold_v_q) begin
                shreg_q   <= scaled;
                hold_v_q  <= 1'b0;
                bit_cnt_q <= '0;
              end else if (frame_pend_q) begin
                state_q      <= LATCH;
                latch_cnt_q  <= '0;
                frame_pend_q <= 1'b0;
              end else begin
                state_q    <= IDLE;
                underrun_q <= 1'b1;
              end
            end else begin
              shreg_q   <= shifted;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        LATCH: begin
          if (latch_cnt_q == LATCH_LAST) state_q <= IDLE;
          else latch_cnt_q <= latch_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      if (take) begin
        hold_q   <= pix_data;
        hold_v_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cube_pixel_serializer.sv
// tb/tb_cube_pixel_serializer.sv - directed self-checking bench for cube_pixel_serializer
module tb_cube_pixel_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] pix_data, l_pix_data;
  logic        pix_valid, l_pix_valid, frame_end, l_frame_end;
  logic [2:0]  dim, l_dim;
  logic        pix_ready, busy, underrun, l_pix_ready, l_busy, l_underrun;
  logic [1:0]  sout, l_sout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [1:0] rec [0:799];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cube_pixel_serializer #(.CHANNELS(2), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_end(frame_end), .dim(dim), .sout(sout),
    .busy(busy), .underrun(underrun)
  );

  cube_pixel_serializer #(.CHANNELS(2), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .pix_data(l_pix_data), .pix_valid(l_pix_valid),
    .pix_ready(l_pix_ready), .frame_end(l_frame_end), .dim(l_dim), .sout(l_sout),
    .busy(l_busy), .underrun(l_underrun)
  );

  // Expected waveform of one 24-bit pixel; index i is the i-th cycle after the first rise.
  function automatic logic [239:0] enc_stream(input logic [23:0] v, input bit msb);
    logic [239:0] s;
    logic b;
    for (int k = 0; k < 24; k++) begin
      b = msb ? v[23-k] : v[k];
      for (int p = 0; p < 10; p++) s[k*10+p] = (p < (b ? 7 : 3));
    end
    return s;
  endfunction

  function automatic logic [239:0] chan_stream(input int ch, input int off);
    logic [239:0] s;
    for (int i = 0; i < 240; i++) s[i] = rec[off+i][ch];
    return s;
  endfunction

  task automatic capture(input int n, input bit use_l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec[i] = use_l ? l_sout : sout;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_valid = 1'b0; frame_end = 1'b0; dim = 3'd0; pix_data = '0;
    l_pix_valid = 1'b0; l_frame_end = 1'b0; l_dim = 3'd0; l_pix_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_m(input logic [47:0] d, input bit keep, output int acc);
    int k;
    pix_data = d;
    pix_valid = 1'b1;
    k = 0;
    while (!pix_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      checks++; errors++;
      $display("FAIL send_timeout: pix_ready=%b after %0d cycles, required 1", pix_ready, k);
    end
    acc = cyc;
    @(negedge clk);
    if (!keep) pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({sout, pix_ready, busy, underrun} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_state: got %b required 00100", {sout, pix_ready, busy, underrun});
    end
    checks++;
    if ({l_sout, l_pix_ready, l_busy, l_underrun} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_state_l: got %b required 00100", {l_sout, l_pix_ready, l_busy, l_underrun});
    end
  endtask

  task automatic test_basic_frame();
    int a, bad;
    do_reset();
    send_m({24'h000001, 24'h800000}, 1'b0, a);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    checks++;
    if (sout !== 2'b00) begin errors++; $display("FAIL pre_rise1: sout=%b required 00", sout); end
    @(negedge clk);
    checks++;
    if (sout !== 2'b00) begin errors++; $display("FAIL pre_rise2: sout=%b required 00", sout); end
    capture(240, 1'b0);
    checks++;
    if (chan_stream(0, 0) !== enc_stream(24'h800000, 1'b1)) begin
      errors++;
      $display("FAIL basic_ch0: got %h required %h", chan_stream(0, 0), enc_stream(24'h800000, 1'b1));
    end
    checks++;
    if (chan_stream(1, 0) !== enc_stream(24'h000001, 1'b1)) begin
      errors++;
      $display("FAIL basic_ch1: got %h required %h", chan_stream(1, 0), enc_stream(24'h000001, 1'b1));
    end
    bad = 0;
    for (int i = 0; i < 499; i++) begin
      @(negedge clk);
      if (sout !== 2'b00 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL latch_low: %0d bad cycles, required 0", bad); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_drop: busy=%b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, start;
    logic [47:0] p [0:2];
    p[0] = {24'h123456, 24'hA5C3F0};
    p[1] = {24'h000000, 24'h0F1E2D};
    p[2] = {24'h800001, 24'hFFFFFF};
    do_reset();
    start = cyc;
    fork
      begin
        send_m(p[0], 1'b1, a0);
        send_m(p[1], 1'b1, a1);
        send_m(p[2], 1'b0, a2);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
      end
      capture(740, 1'b0);
    join
    checks++;
    if (a0 - start !== 0) begin errors++; $display("FAIL accept0: cycle %0d required 0", a0 - start); end
    checks++;
    if (a1 - start !== 3) begin errors++; $display("FAIL accept1: cycle %0d required 3", a1 - start); end
    checks++;
    if (a2 - start !== 243) begin errors++; $display("FAIL accept2: cycle %0d required 243", a2 - start); end
    checks++;
    if ({rec[0], rec[1], rec[2]} !== 6'b0) begin
      errors++; $display("FAIL b2b_lead: got %b required 000000", {rec[0], rec[1], rec[2]});
    end
    for (int n = 0; n < 3; n++)
      for (int ch = 0; ch < 2; ch++) begin
        checks++;
        if (chan_stream(ch, 3 + 240*n) !== enc_stream(p[n][ch*24 +: 24], 1'b1)) begin
          errors++;
          $display("FAIL b2b_px%0d_ch%0d: got %h required %h", n, ch,
                   chan_stream(ch, 3 + 240*n), enc_stream(p[n][ch*24 +: 24], 1'b1));
        end
      end
    checks++;
    if (rec[723] !== 2'b00) begin errors++; $display("FAIL b2b_tail: sout=%b required 00", rec[723]); end
  endtask

  task automatic test_dim();
    int a;
    do_reset();
    dim = 3'd2;
    send_m({24'hFFFFFF, 24'hFF0F04}, 1'b0, a);
    @(negedge clk);
    dim = 3'd0;
    @(negedge clk);
    capture(240, 1'b0);
    checks++;
    if (chan_stream(0, 0) !== enc_stream(24'h3F0301, 1'b1)) begin
      errors++;
      $display("FAIL dim_ch0: got %h required %h", chan_stream(0, 0), enc_stream(24'h3F0301, 1'b1));
    end
    checks++;
    if (chan_stream(1, 0) !== enc_stream(24'h3F3F3F, 1'b1)) begin
      errors++;
      $display("FAIL dim_ch1: got %h required %h", chan_stream(1, 0), enc_stream(24'h3F3F3F, 1'b1));
    end
  endtask

  task automatic test_underrun();
    int a, early;
    do_reset();
    send_m({24'h0000F0, 24'hC30000}, 1'b0, a);
    repeat (2) @(negedge clk);
    early = 0;
    for (int i = 0; i < 239; i++) begin
      @(negedge clk);
      rec[i] = sout;
      if (underrun !== 1'b0) early++;
    end
    @(negedge clk);
    rec[239] = sout;
    checks++;
    if (early !== 0) begin errors++; $display("FAIL underrun_early: %0d pulses, required 0", early); end
    checks++;
    if ({underrun, busy, sout} !== 4'b1000) begin
      errors++; $display("FAIL underrun_pulse: got %b required 1000", {underrun, busy, sout});
    end
    checks++;
    if (chan_stream(0, 0) !== enc_stream(24'hC30000, 1'b1)) begin
      errors++;
      $display("FAIL underrun_ch0: got %h required %h", chan_stream(0, 0), enc_stream(24'hC30000, 1'b1));
    end
    @(negedge clk);
    checks++;
    if ({underrun, busy, sout} !== 4'b0000) begin
      errors++; $display("FAIL underrun_after: got %b required 0000", {underrun, busy, sout});
    end
  endtask

  task automatic test_reset_mid();
    int a, bad;
    do_reset();
    send_m({24'hFFFFFF, 24'hFFFFFF}, 1'b0, a);
    send_m({24'hAAAAAA, 24'h555555}, 1'b0, a);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    repeat (96) @(negedge clk);
    checks++;
    if ({busy, pix_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_pre: busy,ready=%b required 10", {busy, pix_ready});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sout, pix_ready, busy, underrun} !== 5'b00100) begin
      errors++; $display("FAIL mid_reset: got %b required 00100", {sout, pix_ready, busy, underrun});
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sout !== 2'b00 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mid_no_latch: %0d active cycles, required 0", bad); end
  endtask

  task automatic test_lsb_first();
    do_reset();
    checks++;
    if (l_pix_ready !== 1'b1) begin errors++; $display("FAIL lsb_ready: got %b required 1", l_pix_ready); end
    l_pix_data = {24'h800000, 24'h000001};
    l_pix_valid = 1'b1;
    @(negedge clk);
    l_pix_valid = 1'b0;
    l_frame_end = 1'b1;
    @(negedge clk);
    l_frame_end = 1'b0;
    @(negedge clk);
    capture(240, 1'b1);
    checks++;
    if (chan_stream(0, 0) !== enc_stream(24'h000001, 1'b0)) begin
      errors++;
      $display("FAIL lsb_ch0: got %h required %h", chan_stream(0, 0), enc_stream(24'h000001, 1'b0));
    end
    checks++;
    if (chan_stream(1, 0) !== enc_stream(24'h800000, 1'b0)) begin
      errors++;
      $display("FAIL lsb_ch1: got %h required %h", chan_stream(1, 0), enc_stream(24'h800000, 1'b0));
    end
  endtask

  task automatic test_latch_only();
    int k, bad;
    do_reset();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    k = 0;
    bad = 0;
    while (busy && k < 1000) begin
      if (sout !== 2'b00) bad++;
      k++;
      @(negedge clk);
    end
    checks++;
    if (k !== 500) begin errors++; $display("FAIL latch_only_len: %0d busy cycles, required 500", k); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL latch_only_low: %0d high cycles, required 0", bad); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_dim();
    test_underrun();
    test_reset_mid();
    test_lsb_first();
    test_latch_only();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
